// File: rtl/conv1_ofmap_collector.sv
// ---------------------------------------------------------------------------
// conv1_ofmap_collector
//
// Receives the pooled output stream of conv layer 1 and stores one complete
// frame in a single-port BRAM. The frame holds CO channels of O_SIZE x O_SIZE
// words, stored channel-major. Once the frame is complete, the block replays
// it in capture order to the conv layer 2 input. The consumer pulls each word
// with i_rd_ce.
//
// Ports
//   clk             rising-edge clock
//   global_rst_n    asynchronous active-low reset
//   rst_processEnd  synchronous clear before the next image (BRAM contents kept)
//   i_data          pooled result from conv1 (BW bits, signed)
//   i_valid         i_data valid this cycle
//   i_ch_end        channel-complete pulse (may coincide with the last i_valid)
//   i_allch_end     all-channels-done indication from conv1
//   i_rd_ce         consumer pull request for the next stored word
//   o_data          replayed word (0 whenever o_valid is low)
//   o_valid         o_data valid, one cycle after an accepted pull
//   o_ch_end        high with the last word of each channel
//   o_end           high with the final word of the frame
//   o_full          frame captured and replay not yet finished
//   o_err           sticky protocol error
// ---------------------------------------------------------------------------
module conv1_ofmap_collector #(
    parameter int BW     = 16,
    parameter int CO     = 4,
    parameter int O_SIZE = 12,
    parameter int ADDR_W = 10
) (
    input  logic          clk,
    input  logic          global_rst_n,
    input  logic          rst_processEnd,
    input  logic [BW-1:0] i_data,
    input  logic          i_valid,
    input  logic          i_ch_end,
    input  logic          i_allch_end,
    input  logic          i_rd_ce,
    output logic [BW-1:0] o_data,
    output logic          o_valid,
    output logic          o_ch_end,
    output logic          o_end,
    output logic          o_full,
    output logic          o_err
);

    localparam int WPC   = O_SIZE * O_SIZE;
    localparam int TOTAL = CO * WPC;
    localparam int CH_W  = $clog2(CO + 1);
    localparam int PIX_W = $clog2(WPC + 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FULL    = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state;
    logic [CH_W-1:0]   ch;
    logic [PIX_W-1:0]  pix;
    logic [ADDR_W-1:0] rd_addr;

    logic [BW-1:0]     mem [0:TOTAL-1];
    logic [BW-1:0]     rd_q;

    logic              in_collect;
    logic              in_replay;
    logic              pix_full;
    logic              wr_en;
    logic              rd_accept;
    logic [PIX_W-1:0]  pix_after;
    logic [CH_W-1:0]   ch_after;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic              chan_last;
    logic              frame_last;

    assign in_collect = (state == COLLECT);
    assign in_replay  = (state == FULL) || (state == DRAIN);
    assign pix_full   = (pix == PIX_W'(WPC));

    // A write is only legal while the current channel still has room; a word
    // arriving with pix already at WPC is dropped and flagged as an error.
    assign wr_en      = in_collect && i_valid && !pix_full;
    assign rd_accept  = in_replay && i_rd_ce;

    // Word count and channel index as they stand after this cycle's write and
    // channel end. The ch_end length check and the end-of-frame decision use these.
    assign pix_after  = pix + PIX_W'(wr_en);
    assign ch_after   = ch + CH_W'(i_ch_end);

    assign wr_addr    = ADDR_W'(ch) * ADDR_W'(WPC) + ADDR_W'(pix);
    assign mem_addr   = in_collect ? wr_addr : rd_addr;

    assign chan_last  = ((int'(rd_addr) + 1) % WPC) == 0;
    assign frame_last = (rd_addr == ADDR_W'(TOTAL - 1));

    assign o_full     = in_replay;
    assign o_data     = o_valid ? rd_q : '0;

    // Single-port frame store. Capture and replay occupy disjoint states, so
    // one shared address is enough. The memory has no reset so it maps to block RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !rst_processEnd) begin
            mem[mem_addr] <= i_data;
        end else if (rd_accept && !rst_processEnd) begin
            rd_q <= mem[mem_addr];
        end
    end

    // Control FSM: capture counters, replay address, and registered status
    // outputs. rst_processEnd returns everything to the post-reset state
    // without touching the stored frame.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state    <= COLLECT;
            ch       <= '0;
            pix      <= '0;
            rd_addr  <= '0;
            o_valid  <= 1'b0;
            o_ch_end <= 1'b0;
            o_end    <= 1'b0;
            o_err    <= 1'b0;
        end else if (rst_processEnd) begin
            state    <= COLLECT;
            ch       <= '0;
            pix      <= '0;
            rd_addr  <= '0;
            o_valid  <= 1'b0;
            o_ch_end <= 1'b0;
            o_end    <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            o_valid  <= rd_accept;
            o_ch_end <= rd_accept && chan_last;
            o_end    <= rd_accept && frame_last;

            case (state)
                COLLECT: begin
                    if (i_valid) begin
                        if (pix_full) begin
                            o_err <= 1'b1;
                        end else begin
                            pix <= pix + PIX_W'(1);
                        end
                    end
                    // The coincident write is already counted in pix_after,
                    // so a channel ending on its last word checks out clean.
                    if (i_ch_end) begin
                        if (pix_after != PIX_W'(WPC)) begin
                            o_err <= 1'b1;
                        end
                        pix <= '0;
                        ch  <= ch_after;
                    end
                    if (ch_after == CH_W'(CO)) begin
                        state <= FULL;
                    end else if (i_allch_end) begin
                        // conv1 reports completion before every channel has
                        // arrived. Hand over what we have and flag an error.
                        o_err <= 1'b1;
                        state <= FULL;
                    end
                end
                FULL, DRAIN: begin
                    if (i_valid) begin
                        o_err <= 1'b1;
                    end
                    if (rd_accept) begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                        state   <= frame_last ? DONE : DRAIN;
                    end
                end
                default: begin
                    if (i_valid) begin
                        o_err <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
